// File: rtl/param_shift_pkg.sv
// Shared types for the parametrised shift register: shift modes, control states and
// mode capture. SHIFT_ROTATE_EN enables the rotate-right mode.
package param_shift_pkg;

    typedef enum logic [1:0] {
        SH_LSR = 2'b00,
        SH_ASR = 2'b01,
        SH_LSL = 2'b10,
        SH_ROR = 2'b11
    } shift_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } shift_state_t;

    // Without rotate support, mode 11 is latched as logical right.
    function automatic shift_mode_t capture_mode(input logic [1:0] m);
`ifdef SHIFT_ROTATE_EN
        return shift_mode_t'(m);
`else
        return (m == 2'b11) ? SH_LSR : shift_mode_t'(m);
`endif
    endfunction

endpackage

// File: rtl/shift_step_counter.sv
// Step counter and control state for param_shift_reg: counts accepted steps after a
// load and flags done once STEPS steps have completed.
module shift_step_counter
    import param_shift_pkg::*;
#(
    parameter int unsigned STEPS = 8,
    parameter int unsigned CW    = $clog2(STEPS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          done,
    output logic          busy
);

    localparam logic [CW-1:0] LastCount = CW'(STEPS - 1);

    shift_state_t  state_q, state_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (clr) begin
            state_d = ST_RUN;
            count_d = '0;
        end else if (inc && state_q == ST_RUN) begin
            count_d = count_q + CW'(1);
            if (count_q == LastCount) begin
                state_d = ST_DONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign done  = (state_q == ST_DONE);
    assign busy  = (state_q == ST_RUN);

endmodule

// File: rtl/param_shift_reg.sv
// Multi-mode shift register: loads an N-bit operand and shifts STEP bits per enabled cycle
// in the mode latched at load. Rotate right exists only when SHIFT_ROTATE_EN is defined.
module param_shift_reg
    import param_shift_pkg::*;
#(
    parameter  int unsigned N     = 8,
    parameter  int unsigned STEP  = 1,
    localparam int unsigned STEPS = N / STEP,
    localparam int unsigned CW    = $clog2(STEPS + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            en,
    input  logic [N-1:0]    din,
    input  logic [1:0]      mode,
    input  logic [STEP-1:0] sin,
    output logic [N-1:0]    dout,
    output logic [STEP-1:0] sout,
    output logic [CW-1:0]   count,
    output logic            done,
    output logic            busy
);

    if (N < 2 || N % STEP != 0 || !(STEP == 1 || STEP == 2 || STEP == 4)) begin : g_bad_cfg
        $error("param_shift_reg: illegal N/STEP combination");
    end

    logic [N-1:0]    dout_q, dout_d;
    logic [STEP-1:0] sout_q, sout_d;
    shift_mode_t     mode_q, mode_d;
    logic            busy_w;
    logic            step;

    // load has priority over en; steps are only accepted while running.
    assign step = en && !load && busy_w;

    always_comb begin
        dout_d = dout_q;
        sout_d = sout_q;
        mode_d = mode_q;
        if (load) begin
            dout_d = din;
            sout_d = '0;
            mode_d = capture_mode(mode);
        end else if (step) begin
            sout_d = dout_q[STEP-1:0];
            case (mode_q)
                SH_ASR: dout_d = {{STEP{dout_q[N-1]}}, dout_q[N-1:STEP]};
                SH_LSL: begin
                    dout_d = {dout_q[N-STEP-1:0], sin};
                    sout_d = dout_q[N-1:N-STEP];
                end
`ifdef SHIFT_ROTATE_EN
                SH_ROR: dout_d = {dout_q[STEP-1:0], dout_q[N-1:STEP]};
`endif
                default: dout_d = {sin, dout_q[N-1:STEP]};
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
            sout_q <= '0;
            mode_q <= SH_LSR;
        end else begin
            dout_q <= dout_d;
            sout_q <= sout_d;
            mode_q <= mode_d;
        end
    end

    shift_step_counter #(
        .STEPS (STEPS),
        .CW    (CW)
    ) u_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (load),
        .inc   (en),
        .count (count),
        .done  (done),
        .busy  (busy_w)
    );

    assign dout = dout_q;
    assign sout = sout_q;
    assign busy = busy_w;

endmodule

// File: doc/param_shift_reg.md
# param_shift_reg

Parametrised multi-mode shift register for the sequential datapath (shift-add multiplier and shift-subtract divider operands). It loads an N-bit operand, then shifts STEP bits per enabled cycle in a mode latched at load time. It counts completed steps and raises a done flag after N/STEP shifts. It also presents the bits shifted out on each step, so the controller needs no separate counter.

## Interface
- N, 8, register width in bits; N ≥ 2.
- STEP, 1, bits shifted per enabled cycle; must divide N; legal values 1, 2, 4.
- STEPS, N/STEP, derived localparam: number of shifts to done.
- CW, $clog2(STEPS+1), derived localparam: width of count.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- load  in  1  load din and mode; clear count and done.
- en  in  1  perform one shift step.
- din  in  N  parallel operand.
- mode  in  2  00 logical right, 01 arithmetic right, 10 logical left, 11 rotate right; sampled only on load.
- sin  in  STEP  serial fill bits for logical modes.
- dout  out  N  register contents.
- sout  out  STEP  bits shifted out by the most recent step (registered).
- count  out  CW  completed steps since load.
- done  out  1  high once count == STEPS; held until load or reset.
- busy  out  1  loaded and not done.

## Operation
- Internal mode_q holds the mode captured at load. A change on the mode input between loads has no effect.
- Logical right: dout <= {sin, dout[N-1:STEP]}; sout <= dout[STEP-1:0].
- Arithmetic right: fills STEP copies of dout[N-1]; sin is ignored; sout as logical right.
- Logical left: dout <= {dout[N-STEP-1:0], sin}; sout <= dout[N-1:N-STEP].
- Rotate right: dout <= {dout[STEP-1:0], dout[N-1:STEP]}; sout as logical right. Mode is gated by the macro (see Configuration).
- Each accepted step increments count by 1. done sets on the edge where count goes STEPS-1 → STEPS.
- State: IDLE (after reset; no operand), RUN (busy=1), DONE (done=1).
  - IDLE → RUN on load.
  - RUN → DONE on the final step.
  - DONE → RUN on load.
  - en in IDLE or DONE is ignored: dout, sout and count hold.
- load and en in the same cycle: load wins; no shift occurs.

## Timing
- Reset values: dout=0, sout=0, count=0, done=0, busy=0, mode_q=00, state IDLE. Reset applies immediately on rst_n low, including mid-operation.
- load at edge k: dout=din, count=0, done=0, busy=1, sout=0 after edge k.
- Shift latency is 1 cycle: en at edge k updates dout, sout and count after edge k.
- After a load, STEPS consecutive en cycles give done=1 and busy=0 after the STEPS-th edge.
- en may be gapped; count only advances on accepted steps.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- SHIFT_ROTATE_EN defined: mode 11 rotates right as specified.
- SHIFT_ROTATE_EN undefined: mode 11 is captured as 00 and behaves exactly as logical right, including sin fill. No rotate mux is synthesised.

## Structure
- Package param_shift_pkg holds:
  - typedef enum shift_mode_t {SH_LSR=2'b00, SH_ASR=2'b01, SH_LSL=2'b10, SH_ROR=2'b11};
  - the state enum {ST_IDLE, ST_RUN, ST_DONE}.
- Sub-module shift_step_counter (params STEPS, CW; ports clk, rst_n, clr, inc, count, done) owns count, done and the state. The top module owns the data path.
- An elaboration-time check rejects N % STEP != 0.

## Test plan
- Reset: assert rst_n=0 mid-RUN at N=8, STEP=1 → dout=00, count=0, done=0, busy=0 immediately.
- Logical right, N=8, STEP=1: load 8'hB4, mode 00, sin=0, then 8 en.
  - dout goes 5A, 2D, 16, 0B, 05, 02, 01, 00.
  - sout goes 0,0,1,0,1,1,0,1.
  - After the 8th edge: count=8, done=1.
- Arithmetic right: load 8'h90, mode 01, sin=1, then 2 en → dout 8'hC8, then 8'hE4.
- Logical left, N=8, STEP=2: load 8'h0F, mode 10, sin=2'b11.
  - 1 en → dout 8'h3F, sout 2'b00.
  - 4 en total → dout 8'hFF, done=1.
  - A 5th en → no change.
- Rotate: load 8'h81, mode 11, 1 en → 8'hC0 with SHIFT_ROTATE_EN; 8'h40 without (sin=0).
- Collisions: load 8'h11 with en=1 in the same cycle → dout 8'h11, count 0. Changing mode mid-RUN → shifts continue in the latched mode.
